// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / load-store) sequencer in
// front of a byte-addressed single-port memory.
//
// One request is accepted at a time over valid/ready. The winning address is
// held on mem_adr for MEM_LAT cycles, the read word is captured on the last of
// them, and it is returned to the winner with a one-cycle response pulse.
// Stores strobe mem_we for the first access cycle only and answer with data 0.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> round-robin between IF and LS when both are
//                               valid; the requester not granted last wins.
//                  undefined -> fixed priority, LS wins over IF.
module mem_arbiter #(
    parameter int XLEN    = 32,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    // Instruction fetch port
    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_req_adr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,

    // Load/store port
    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic [XLEN-1:0] ls_req_adr,
    input  logic            ls_req_we,
    input  logic [3:0]      ls_req_be,
    input  logic [XLEN-1:0] ls_req_wdata,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_resp_data,

    // Memory port
    output logic [XLEN-1:0] mem_adr,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // Owner of the access in flight (1 = LS). It is rewritten on every
    // handshake and resets to IF, so it doubles as the last-grant record for
    // round-robin arbitration.
    logic             owner_ls;
    logic             store_q;

    logic             grant_if;
    logic             grant_ls;
    logic             store_hs;

    // Arbitration: pick a winner among the valid requesters while idle.
    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (rst_n && state == S_IDLE) begin
`ifdef MEM_ARB_RR_EN
            grant_ls = ls_req_valid && (!if_req_valid || !owner_ls);
`else
            grant_ls = ls_req_valid;
`endif
            grant_if = if_req_valid && !grant_ls;
        end
    end

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign store_hs     = grant_ls && ls_req_we;

    // Sequencer: IDLE -> ACCESS -> RESP -> IDLE, with all memory and
    // response outputs registered.
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            owner_ls      <= 1'b0;
            store_q       <= 1'b0;
            mem_adr       <= '0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_wdata     <= '0;
            if_resp_valid <= 1'b0;
            if_resp_data  <= '0;
            ls_resp_valid <= 1'b0;
            ls_resp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_ls) begin
                        owner_ls  <= grant_ls;
                        store_q   <= store_hs;
                        mem_adr   <= grant_ls ? ls_req_adr : if_req_adr;
                        mem_we    <= store_hs;
                        mem_be    <= store_hs ? ls_req_be : 4'b0000;
                        mem_wdata <= store_hs ? ls_req_wdata : '0;
                        cnt       <= LAT_LOAD;
                        state     <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    // Write strobe and data live in the first access cycle only.
                    mem_we    <= 1'b0;
                    mem_be    <= 4'b0000;
                    mem_wdata <= '0;
                    if (cnt == '0) begin
                        if (owner_ls) begin
                            ls_resp_valid <= 1'b1;
                            ls_resp_data  <= store_q ? '0 : mem_rdata;
                        end else begin
                            if_resp_valid <= 1'b1;
                            if_resp_data  <= mem_rdata;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_RESP: begin
                    // mem_adr keeps the last address so the memory input stays quiet.
                    if_resp_valid <= 1'b0;
                    ls_resp_valid <= 1'b0;
                    state         <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Structural invariants of the sequencer.
    a_one_ready : assert property (@(posedge clk) disable iff (!rst_n)
        !(if_req_ready && ls_req_ready));
    a_one_resp  : assert property (@(posedge clk) disable iff (!rst_n)
        !(if_resp_valid && ls_resp_valid));
    a_we_pulse  : assert property (@(posedge clk) disable iff (!rst_n)
        mem_we |=> !mem_we);

endmodule
